// File: rtl/wb_resp_stage_pkg.sv
// wb_resp_stage_pkg: opcode, access-size and state encodings shared by the writeback slice.
// Rev 1.0
`default_nettype none

package wb_resp_stage_pkg;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_BL  = 8'h02;
  localparam logic [7:0] OP_LD  = 8'h10;
  localparam logic [7:0] OP_LDU = 8'h11;
  localparam logic [7:0] OP_LL  = 8'h12;

  localparam logic [1:0] ACCESS_SZ_BYTE  = 2'd0;
  localparam logic [1:0] ACCESS_SZ_HALF  = 2'd1;
  localparam logic [1:0] ACCESS_SZ_WORD  = 2'd2;
  localparam logic [1:0] ACCESS_SZ_DWORD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_GO   = 2'd2
  } ws_state_e;

endpackage

`default_nettype wire

// File: rtl/wb_resp_stage_if.sv
// wb_resp_stage_if: MEM-to-WB handshake, load-response channel and regfile/forwarding outputs.
// Rev 1.0
`default_nettype none

interface wb_resp_stage_if #(
  parameter int DATA_W = 32,
  parameter int RF_AW  = 5,
  parameter int OP_W   = 8
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic              ms_to_ws_valid;
  logic              ws_allowin;
  logic [31:0]       ms_pc;
  logic [OP_W-1:0]   ms_op;
  logic [RF_AW-1:0]  ms_dest;
  logic [DATA_W-1:0] ms_result;
  logic [1:0]        ms_sz;
  logic [OFF_W-1:0]  ms_offset;
  logic              data_resp_valid;
  logic              data_resp_ready;
  logic [DATA_W-1:0] data_resp_rdata;
  logic              rf_we;
  logic [RF_AW-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              ws_fwd_valid;
  logic [RF_AW-1:0]  ws_fwd_dest;
  logic              ws_fwd_data_ok;
  logic [31:0]       ws_pc;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_op, ms_dest, ms_result, ms_sz, ms_offset,
    output data_resp_valid, data_resp_rdata,
    input  ws_allowin, data_resp_ready, rf_we, rf_waddr, rf_wdata,
    input  ws_fwd_valid, ws_fwd_dest, ws_fwd_data_ok, ws_pc
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_op, ms_dest, ms_result, ms_sz, ms_offset,
    input  data_resp_valid, data_resp_rdata,
    output ws_allowin, data_resp_ready, rf_we, rf_waddr, rf_wdata,
    output ws_fwd_valid, ws_fwd_dest, ws_fwd_data_ok, ws_pc
  );

endinterface

`default_nettype wire

// File: rtl/wb_resp_fifo.sv
// wb_resp_fifo: in-order load-response FIFO, DATA_W x DEPTH, asynchronous active-high reset.
// Rev 1.0
`default_nettype none

module wb_resp_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              i_push,
  input  wire logic [DATA_W-1:0] i_wdata,
  input  wire logic              i_pop,
  output logic      [DATA_W-1:0] o_rdata,
  output logic                   o_empty,
  output logic                   o_full,
  output logic      [CW-1:0]     o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= ptr_next(r_wptr);
      end
      if (w_do_pop) begin
        r_rptr <= ptr_next(r_rptr);
      end
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_resp_stage.sv
// wb_resp_stage: writeback pipeline register; stalls loads for their response, extracts and extends the lane.
// Rev 1.0
`default_nettype none

module wb_resp_stage
  import wb_resp_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int RF_AW      = 5,
  parameter int OP_W       = 8,
  parameter int RESP_DEPTH = 2
) (
  input wire logic         clk,
  input wire logic         reset,
  wb_resp_stage_if.slave   bus
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  ws_state_e         r_state;
  logic [31:0]       r_pc;
  logic [OP_W-1:0]   r_op;
  logic [RF_AW-1:0]  r_dest;
  logic [DATA_W-1:0] r_result;
  logic [1:0]        r_sz;
  logic [OFF_W-1:0]  r_offset;

  logic              w_valid;
  logic              w_is_load;
  logic              w_in_is_load;
  logic              w_ready_go;
  logic              w_allowin;
  logic              w_accept;
  logic              w_bypass;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [DATA_W-1:0] w_fifo_head;
  logic [DATA_W-1:0] w_raw;
  logic [OFF_W-1:0]  w_off_mask;
  logic [OFF_W-1:0]  w_off_eff;
  logic [DATA_W-1:0] w_lane;
  logic [DATA_W-1:0] w_word_ext;
  logic [DATA_W-1:0] w_ld_data;
  logic              w_signed;
  logic              w_is_ll;
  logic [RF_AW-1:0]  w_waddr;
  logic [DATA_W-1:0] w_wdata;

  assign w_valid      = (r_state != S_IDLE);
  assign w_is_load    = (r_op == OP_W'(OP_LD)) || (r_op == OP_W'(OP_LDU)) || (r_op == OP_W'(OP_LL));
  assign w_in_is_load = (bus.ms_op == OP_W'(OP_LD)) || (bus.ms_op == OP_W'(OP_LDU)) ||
                        (bus.ms_op == OP_W'(OP_LL));
  assign w_ready_go   = (r_state == S_GO) || ((r_state == S_WAIT) && bus.data_resp_valid);
  assign w_allowin    = !w_valid || w_ready_go;
  assign w_accept     = bus.ms_to_ws_valid && w_allowin;

  // A waiting load only exists with an empty FIFO, so any response that cycle is consumed directly.
  assign w_bypass   = (r_state == S_WAIT) && bus.data_resp_valid;
  assign w_push     = bus.data_resp_valid && !w_fifo_full && !w_bypass;
  assign w_pop      = (r_state == S_GO) && w_is_load;
  assign w_cnt_next = w_fifo_count + CNT_W'(w_push) - CNT_W'(w_pop);

  wb_resp_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RESP_DEPTH),
    .CW     (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (bus.data_resp_rdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_op     <= '0;
      r_dest   <= '0;
      r_result <= '0;
      r_sz     <= '0;
      r_offset <= '0;
    end else if (w_accept) begin
      // A new load only goes straight to S_GO if its response will already sit in the FIFO.
      r_state  <= (w_in_is_load && (w_cnt_next == '0)) ? S_WAIT : S_GO;
      r_pc     <= bus.ms_pc;
      r_op     <= bus.ms_op;
      r_dest   <= bus.ms_dest;
      r_result <= bus.ms_result;
      r_sz     <= bus.ms_sz;
      r_offset <= bus.ms_offset;
    end else if (w_ready_go) begin
      r_state <= S_IDLE;
    end
  end

  assign w_raw      = w_fifo_empty ? bus.data_resp_rdata : w_fifo_head;
  assign w_off_mask = OFF_W'((32'd1 << r_sz) - 32'd1);
  assign w_off_eff  = r_offset & ~w_off_mask;
  assign w_lane     = w_raw >> {w_off_eff, 3'b000};
  assign w_signed   = (r_op == OP_W'(OP_LD));
  assign w_is_ll    = (r_op == OP_W'(OP_LL));

  generate
    if (DATA_W > 32) begin : g_word_wide
      assign w_word_ext = w_signed ? {{(DATA_W-32){w_lane[31]}}, w_lane[31:0]}
                                   : {{(DATA_W-32){1'b0}}, w_lane[31:0]};
    end else begin : g_word_full
      assign w_word_ext = w_lane;
    end
  endgenerate

  always_comb begin
    w_ld_data = w_lane;
    if (!w_is_ll) begin
      case (r_sz)
        ACCESS_SZ_BYTE:  w_ld_data = w_signed ? {{(DATA_W-8){w_lane[7]}}, w_lane[7:0]}
                                              : {{(DATA_W-8){1'b0}}, w_lane[7:0]};
        ACCESS_SZ_HALF:  w_ld_data = w_signed ? {{(DATA_W-16){w_lane[15]}}, w_lane[15:0]}
                                              : {{(DATA_W-16){1'b0}}, w_lane[15:0]};
        ACCESS_SZ_WORD:  w_ld_data = w_word_ext;
        ACCESS_SZ_DWORD: w_ld_data = w_lane;
        default:         w_ld_data = w_lane;
      endcase
    end
  end

  assign w_waddr = !w_valid ? '0 : (r_op == OP_W'(OP_BL)) ? RF_AW'(1) : r_dest;
  assign w_wdata = !w_valid ? '0 : w_is_load ? w_ld_data : r_result;

  assign bus.ws_allowin      = w_allowin;
  assign bus.data_resp_ready = !w_fifo_full;
  assign bus.rf_we           = w_valid && w_ready_go && (w_waddr != '0);
  assign bus.rf_waddr        = w_waddr;
  assign bus.rf_wdata        = w_wdata;
  assign bus.ws_fwd_valid    = w_valid && (w_waddr != '0);
  assign bus.ws_fwd_dest     = w_waddr;
  assign bus.ws_fwd_data_ok  = w_valid && w_ready_go;
  assign bus.ws_pc           = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_wb_resp_stage.sv
// tb_wb_resp_stage: directed scenarios plus randomized traffic against a queue-based reference model.
// Rev 1.0
`default_nettype none

module tb_wb_resp_stage;
  import wb_resp_stage_pkg::*;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [7:0]  op;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [1:0]  sz;
    logic [1:0]  off;
    logic [31:0] pc;
  } instr_t;

  always #5 clk = ~clk;

  wb_resp_stage_if #(.DATA_W(32), .RF_AW(5), .OP_W(8)) bus ();

  wb_resp_stage #(
    .DATA_W     (32),
    .RF_AW      (5),
    .OP_W       (8),
    .RESP_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic bit is_ld(input logic [7:0] op);
    return (op == OP_LD) || (op == OP_LDU) || (op == OP_LL);
  endfunction

  // Gather the addressed bytes one by one, then extend by the opcode's rule.
  function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [1:0] sz,
                                           input logic [1:0] off, input logic [31:0] data);
    int n;
    int start;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    start = int'(off) - (int'(off) % n);
    if (op == OP_LL) return data >> (8 * start);
    v = '0;
    for (int j = 0; j < n; j++) v[8*j +: 8] = data[8*(start+j) +: 8];
    if (op == OP_LD && n < 4 && v[8*n-1]) begin
      for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ms_to_ws_valid  = 1'b0;
    bus.ms_pc           = '0;
    bus.ms_op           = '0;
    bus.ms_dest         = '0;
    bus.ms_result       = '0;
    bus.ms_sz           = '0;
    bus.ms_offset       = '0;
    bus.data_resp_valid = 1'b0;
    bus.data_resp_rdata = '0;
  endtask

  task automatic set_instr(input logic [7:0] op, input logic [4:0] dest, input logic [31:0] res,
                           input logic [1:0] sz, input logic [1:0] off, input logic [31:0] pc);
    bus.ms_to_ws_valid = 1'b1;
    bus.ms_op          = op;
    bus.ms_dest        = dest;
    bus.ms_result      = res;
    bus.ms_sz          = sz;
    bus.ms_offset      = off;
    bus.ms_pc          = pc;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.ws_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin got=%b exp=1", bus.ws_allowin); end
    checks++; if (bus.data_resp_ready !== 1'b1) begin errors++; $display("FAIL rst_resp_ready got=%b exp=1", bus.data_resp_ready); end
    checks++; if (bus.rf_we !== 1'b0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0)
      begin errors++; $display("FAIL rst_rf got we=%b a=%0d d=%h exp 0/0/0", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.ws_fwd_valid !== 1'b0 || bus.ws_fwd_dest !== 5'd0 || bus.ws_fwd_data_ok !== 1'b0 || bus.ws_pc !== 32'd0)
      begin errors++; $display("FAIL rst_fwd got v=%b d=%0d ok=%b pc=%h exp zeros", bus.ws_fwd_valid, bus.ws_fwd_dest, bus.ws_fwd_data_ok, bus.ws_pc); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_alu();
    set_instr(OP_ADD, 5'd5, 32'h1234, ACCESS_SZ_WORD, 2'd0, 32'h1C00_0010);
    @(negedge clk);
    checks++; if (bus.ws_allowin !== 1'b1) begin errors++; $display("FAIL alu_allowin got=%b exp=1", bus.ws_allowin); end
    step();
    bus.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd5 || bus.rf_wdata !== 32'h1234)
      begin errors++; $display("FAIL alu_write got we=%b a=%0d d=%h exp 1/5/00001234", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.ws_fwd_data_ok !== 1'b1 || bus.ws_fwd_dest !== 5'd5 || bus.ws_pc !== 32'h1C00_0010)
      begin errors++; $display("FAIL alu_fwd got ok=%b d=%0d pc=%h exp 1/5/1c000010", bus.ws_fwd_data_ok, bus.ws_fwd_dest, bus.ws_pc); end
    step();
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL alu_idle_we got=%b exp=0", bus.rf_we); end
    step();
  endtask

  task automatic test_ld_byte();
    set_instr(OP_LD, 5'd7, 32'd0, ACCESS_SZ_BYTE, 2'd2, 32'h1C00_0020);
    @(negedge clk);
    step();
    bus.ms_to_ws_valid  = 1'b0;
    bus.data_resp_valid = 1'b1;
    bus.data_resp_rdata = 32'h0080_0000;
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd7 || bus.rf_wdata !== 32'hFFFF_FF80)
      begin errors++; $display("FAIL ldb_write got we=%b a=%0d d=%h exp 1/7/ffffff80", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.ws_allowin !== 1'b1) begin errors++; $display("FAIL ldb_allowin got=%b exp=1", bus.ws_allowin); end
    step();
    bus.data_resp_valid = 1'b0;
    step();
  endtask

  task automatic test_ldu_late();
    set_instr(OP_LDU, 5'd9, 32'd0, ACCESS_SZ_HALF, 2'd2, 32'h1C00_0030);
    @(negedge clk);
    step();
    bus.ms_to_ws_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (bus.ws_allowin !== 1'b0 || bus.rf_we !== 1'b0 || bus.ws_fwd_data_ok !== 1'b0)
        begin errors++; $display("FAIL ldu_stall c%0d got allow=%b we=%b ok=%b exp 0/0/0", k, bus.ws_allowin, bus.rf_we, bus.ws_fwd_data_ok); end
      step();
    end
    bus.data_resp_valid = 1'b1;
    bus.data_resp_rdata = 32'hBEEF_0000;
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 32'h0000_BEEF || bus.ws_allowin !== 1'b1)
      begin errors++; $display("FAIL ldu_write got we=%b d=%h allow=%b exp 1/0000beef/1", bus.rf_we, bus.rf_wdata, bus.ws_allowin); end
    step();
    bus.data_resp_valid = 1'b0;
  endtask

  task automatic test_fifo_full();
    bus.data_resp_valid = 1'b1;
    bus.data_resp_rdata = 32'hA1A2_A3A4;
    @(negedge clk);
    checks++; if (bus.data_resp_ready !== 1'b1) begin errors++; $display("FAIL ff_ready0 got=%b exp=1", bus.data_resp_ready); end
    step();
    bus.data_resp_rdata = 32'hB1B2_B3B4;
    step();
    bus.data_resp_rdata = 32'hC0C0_C0C0;
    @(negedge clk);
    checks++; if (bus.data_resp_ready !== 1'b0) begin errors++; $display("FAIL ff_full_ready got=%b exp=0", bus.data_resp_ready); end
    step();
    set_instr(OP_LD, 5'd3, 32'd0, ACCESS_SZ_WORD, 2'd0, 32'h1C00_0040);
    step();
    set_instr(OP_LD, 5'd4, 32'd0, ACCESS_SZ_WORD, 2'd0, 32'h1C00_0044);
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd3 || bus.rf_wdata !== 32'hA1A2_A3A4)
      begin errors++; $display("FAIL ff_first got we=%b a=%0d d=%h exp 1/3/a1a2a3a4", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    checks++; if (bus.data_resp_ready !== 1'b0 || bus.ws_allowin !== 1'b1)
      begin errors++; $display("FAIL ff_pop_ready got rdy=%b allow=%b exp 0/1", bus.data_resp_ready, bus.ws_allowin); end
    step();
    bus.ms_to_ws_valid  = 1'b0;
    bus.data_resp_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd4 || bus.rf_wdata !== 32'hB1B2_B3B4)
      begin errors++; $display("FAIL ff_second got we=%b a=%0d d=%h exp 1/4/b1b2b3b4", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
    step();
  endtask

  task automatic test_bl();
    set_instr(OP_BL, 5'd0, 32'h1C00_0054, ACCESS_SZ_WORD, 2'd0, 32'h1C00_0050);
    @(negedge clk);
    step();
    set_instr(OP_ADD, 5'd0, 32'h55, ACCESS_SZ_WORD, 2'd0, 32'h1C00_0054);
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 5'd1 || bus.rf_wdata !== 32'h1C00_0054 || bus.ws_fwd_valid !== 1'b1)
      begin errors++; $display("FAIL bl_write got we=%b a=%0d d=%h fv=%b exp 1/1/1c000054/1", bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.ws_fwd_valid); end
    step();
    bus.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b0 || bus.ws_fwd_data_ok !== 1'b1 || bus.ws_fwd_valid !== 1'b0 || bus.ws_fwd_dest !== 5'd0)
      begin errors++; $display("FAIL r0_write got we=%b ok=%b fv=%b fd=%0d exp 0/1/0/0", bus.rf_we, bus.ws_fwd_data_ok, bus.ws_fwd_valid, bus.ws_fwd_dest); end
    step();
  endtask

  task automatic test_reset_wait();
    set_instr(OP_LD, 5'd6, 32'd0, ACCESS_SZ_WORD, 2'd0, 32'h1C00_0060);
    step();
    bus.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.ws_allowin !== 1'b0) begin errors++; $display("FAIL rw_stall got=%b exp=0", bus.ws_allowin); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.ws_allowin !== 1'b1 || bus.rf_we !== 1'b0 || bus.ws_fwd_data_ok !== 1'b0 || bus.ws_pc !== 32'd0 || bus.rf_waddr !== 5'd0)
      begin errors++; $display("FAIL rw_reset got allow=%b we=%b ok=%b pc=%h a=%0d exp 1/0/0/0/0", bus.ws_allowin, bus.rf_we, bus.ws_fwd_data_ok, bus.ws_pc, bus.rf_waddr); end
    step();
    reset = 1'b0;
    bus.data_resp_valid = 1'b1;
    bus.data_resp_rdata = 32'h1122_3344;
    @(negedge clk);
    checks++; if (bus.data_resp_ready !== 1'b1 || bus.rf_we !== 1'b0)
      begin errors++; $display("FAIL rw_resp got rdy=%b we=%b exp 1/0", bus.data_resp_ready, bus.rf_we); end
    step();
    bus.data_resp_valid = 1'b0;
    set_instr(OP_LD, 5'd6, 32'd0, ACCESS_SZ_WORD, 2'd0, 32'h1C00_0064);
    step();
    bus.ms_to_ws_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 32'h1122_3344)
      begin errors++; $display("FAIL rw_after got we=%b d=%h exp 1/11223344", bus.rf_we, bus.rf_wdata); end
    step();
  endtask

  function automatic instr_t rand_instr();
    instr_t t;
    case ($urandom_range(0, 4))
      0:       t.op = OP_ADD;
      1:       t.op = OP_BL;
      2:       t.op = OP_LD;
      3:       t.op = OP_LDU;
      default: t.op = OP_LL;
    endcase
    t.dest   = 5'($urandom_range(0, 31));
    t.result = $urandom;
    t.sz     = 2'($urandom_range(0, 3));
    t.off    = 2'($urandom_range(0, 3));
    t.pc     = $urandom & 32'hFFFF_FFFC;
    return t;
  endfunction

  task automatic test_random();
    instr_t      iq[$];
    logic [31:0] rq[$];
    int          cons;
    instr_t      cur;
    logic [31:0] rd;
    bit          held, ld, rg, acc, rfire, exp_allow, exp_rr;
    int          queued;
    logic [4:0]  ea;
    logic [31:0] ed;
    cons = 0;
    idle_inputs();
    for (int cyc = 0; cyc < 900; cyc++) begin
      if (cyc >= 700 && iq.size() == 0 && !bus.ms_to_ws_valid) break;
      if (!bus.ms_to_ws_valid && cyc < 700 && $urandom_range(0, 2) != 0) begin
        cur = rand_instr();
        set_instr(cur.op, cur.dest, cur.result, cur.sz, cur.off, cur.pc);
      end
      if (!bus.data_resp_valid && $urandom_range(0, 2) == 0) begin
        bus.data_resp_valid = 1'b1;
        bus.data_resp_rdata = $urandom;
      end
      @(negedge clk);
      held      = (iq.size() != 0);
      queued    = rq.size() - cons;
      ld        = held && is_ld(iq[0].op);
      rg        = held && (!ld || queued > 0 || bus.data_resp_valid);
      exp_allow = !held || rg;
      exp_rr    = (queued < DEPTH);
      checks++; if (bus.ws_allowin !== exp_allow) begin errors++; $display("FAIL rnd_allowin cyc=%0d got=%b exp=%b", cyc, bus.ws_allowin, exp_allow); end
      checks++; if (bus.data_resp_ready !== exp_rr) begin errors++; $display("FAIL rnd_resp_ready cyc=%0d got=%b exp=%b", cyc, bus.data_resp_ready, exp_rr); end
      checks++; if (bus.ws_fwd_data_ok !== rg) begin errors++; $display("FAIL rnd_data_ok cyc=%0d got=%b exp=%b", cyc, bus.ws_fwd_data_ok, rg); end
      if (held) begin
        ea = (iq[0].op == OP_BL) ? 5'd1 : iq[0].dest;
        checks++; if (bus.rf_we !== (rg && ea != 5'd0)) begin errors++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", cyc, bus.rf_we, (rg && ea != 5'd0)); end
        checks++; if (bus.ws_fwd_dest !== ea || bus.ws_pc !== iq[0].pc)
          begin errors++; $display("FAIL rnd_fwd cyc=%0d got dest=%0d pc=%h exp %0d/%h", cyc, bus.ws_fwd_dest, bus.ws_pc, ea, iq[0].pc); end
        if (rg && ea != 5'd0) begin
          ed = ld ? ref_load(iq[0].op, iq[0].sz, iq[0].off, (queued > 0) ? rq[cons] : bus.data_resp_rdata) : iq[0].result;
          checks++; if (bus.rf_waddr !== ea || bus.rf_wdata !== ed)
            begin errors++; $display("FAIL rnd_write cyc=%0d op=%h got a=%0d d=%h exp %0d/%h", cyc, iq[0].op, bus.rf_waddr, bus.rf_wdata, ea, ed); end
        end
      end else begin
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rnd_idle_we cyc=%0d got=%b exp=0", cyc, bus.rf_we); end
      end
      acc   = bus.ms_to_ws_valid && exp_allow;
      rfire = bus.data_resp_valid && exp_rr;
      rd    = bus.data_resp_rdata;
      @(posedge clk);
      if (rfire) rq.push_back(rd);
      if (rg) begin
        if (ld) cons++;
        void'(iq.pop_front());
      end
      if (acc) iq.push_back(cur);
      #1;
      if (acc) bus.ms_to_ws_valid = 1'b0;
      if (rfire) bus.data_resp_valid = 1'b0;
    end
    checks++; if (iq.size() != 0 || bus.ms_to_ws_valid)
      begin errors++; $display("FAIL rnd_drain got pending=%0d exp=0", iq.size()); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_ld_byte();
    test_ldu_late();
    test_fifo_full();
    test_bl();
    test_reset_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
